// File: rtl/mii_tx_framer.sv
`timescale 1ns/1ps
// mii_tx_framer: byte stream to 100BASE-T MII nibbles with preamble, FCS, IFG.
// Define MII_TX_PAD_EN to pad short frames with zeros up to MIN_PAYLOAD.

module mii_tx_framer #(
   parameter int IFG_NIBBLES = 24
`ifdef MII_TX_PAD_EN
   , parameter int MIN_PAYLOAD = 60
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [3:0] mii_txd,
   output logic       mii_txen,
   output logic       mii_txer,
   output logic       busy
);

   localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 1);
`ifdef MII_TX_PAD_EN
   localparam logic [15:0] MIN_P = 16'(MIN_PAYLOAD);
`endif

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_DATA,
`ifdef MII_TX_PAD_EN
      ST_PAD,
`endif
      ST_FCS,
      ST_ERR,
      ST_DROP,
      ST_IFG
   } state_t;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        hi, hi_n;
   logic        last_q, last_n;
   logic [7:0]  byte_q, byte_n;
   logic [31:0] crc, crc_n;
   logic [15:0] nbytes, nbytes_n, nbytes_inc;
   logic [3:0]  txd_n;
   logic        txen_n, txer_n, ready_n, busy_n;
   logic        start, accept, to_fcs;
`ifdef MII_TX_PAD_EN
   logic        pad_byte;
`endif
   logic [31:0] fcs;
   logic [2:0]  fcs_idx;

   assign fcs        = ~crc;
   assign fcs_idx    = cnt[2:0] + 3'd1;
   assign nbytes_inc = (&nbytes) ? nbytes : nbytes + 16'd1;

   // Next state and next registered outputs; outputs track the state entered.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      hi_n     = hi;
      last_n   = last_q;
      byte_n   = byte_q;
      crc_n    = crc;
      nbytes_n = nbytes;
      txd_n    = 4'h0;
      txen_n   = 1'b0;
      txer_n   = 1'b0;
      ready_n  = 1'b0;
      busy_n   = 1'b1;
      start    = 1'b0;
      accept   = 1'b0;
      to_fcs   = 1'b0;
`ifdef MII_TX_PAD_EN
      pad_byte = 1'b0;
`endif
      unique case (state)
         ST_IDLE: begin
            busy_n = 1'b0;
            if (s_valid) start = 1'b1;
         end
         ST_PRE: begin
            txen_n = 1'b1;
            if (cnt == 8'd14) begin
               state_n = ST_SFD;
               txd_n   = 4'hD;
               ready_n = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
               txd_n = 4'h5;
            end
         end
         ST_SFD: accept = 1'b1;
         ST_DATA: begin
            if (!hi) begin
               hi_n    = 1'b1;
               txen_n  = 1'b1;
               txd_n   = byte_q[7:4];
               ready_n = !last_q;
            end else if (!last_q) begin
               accept = 1'b1;
`ifdef MII_TX_PAD_EN
            end else if (nbytes < MIN_P) begin
               pad_byte = 1'b1;
`endif
            end else begin
               to_fcs = 1'b1;
            end
         end
`ifdef MII_TX_PAD_EN
         ST_PAD: begin
            if (!hi) begin
               hi_n   = 1'b1;
               txen_n = 1'b1;
            end else if (nbytes < MIN_P) begin
               pad_byte = 1'b1;
            end else begin
               to_fcs = 1'b1;
            end
         end
`endif
         ST_FCS: begin
            if (cnt == 8'd7) begin
               state_n = ST_IFG;
               cnt_n   = 8'd0;
            end else begin
               cnt_n  = cnt + 8'd1;
               txen_n = 1'b1;
               txd_n  = fcs[{fcs_idx, 2'b00} +: 4];
            end
         end
         ST_ERR: begin
            if (cnt == 8'd1) begin
               state_n = ST_DROP;
               ready_n = 1'b1;
            end else begin
               cnt_n  = cnt + 8'd1;
               txen_n = 1'b1;
               txer_n = 1'b1;
            end
         end
         ST_DROP: begin
            if (s_valid && s_last) begin
               state_n = ST_IFG;
               cnt_n   = 8'd0;
            end else begin
               ready_n = 1'b1;
            end
         end
         ST_IFG: begin
            // A source already waiting starts right after the gap, no idle cycle.
            if (cnt == IFG_LAST) begin
               if (s_valid) begin
                  start = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  busy_n  = 1'b0;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase

      if (start) begin
         state_n  = ST_PRE;
         cnt_n    = 8'd0;
         crc_n    = 32'hFFFFFFFF;
         nbytes_n = 16'd0;
         txen_n   = 1'b1;
         txd_n    = 4'h5;
         busy_n   = 1'b1;
      end

      if (accept) begin
         txen_n = 1'b1;
         if (s_valid) begin
            state_n  = ST_DATA;
            hi_n     = 1'b0;
            byte_n   = s_data;
            last_n   = s_last;
            crc_n    = crc_byte(crc, s_data);
            nbytes_n = nbytes_inc;
            txd_n    = s_data[3:0];
         end else begin
            state_n = ST_ERR;
            cnt_n   = 8'd0;
            txer_n  = 1'b1;
         end
      end

`ifdef MII_TX_PAD_EN
      if (pad_byte) begin
         state_n  = ST_PAD;
         hi_n     = 1'b0;
         crc_n    = crc_byte(crc, 8'h00);
         nbytes_n = nbytes_inc;
         txen_n   = 1'b1;
      end
`endif

      if (to_fcs) begin
         state_n = ST_FCS;
         cnt_n   = 8'd0;
         txen_n  = 1'b1;
         txd_n   = fcs[3:0];
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= 8'd0;
         hi       <= 1'b0;
         last_q   <= 1'b0;
         byte_q   <= 8'h00;
         crc      <= 32'hFFFFFFFF;
         nbytes   <= 16'd0;
         mii_txd  <= 4'h0;
         mii_txen <= 1'b0;
         mii_txer <= 1'b0;
         s_ready  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         hi       <= hi_n;
         last_q   <= last_n;
         byte_q   <= byte_n;
         crc      <= crc_n;
         nbytes   <= nbytes_n;
         mii_txd  <= txd_n;
         mii_txen <= txen_n;
         mii_txer <= txer_n;
         s_ready  <= ready_n;
         busy     <= busy_n;
      end
   end

endmodule
